// File: rtl/beneater_pkg.sv
// Shared constants and enums for the SAP-style CPU datapath and decoder.
package beneater_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    LDA = 4'd1,
    ADD = 4'd2,
    SUB = 4'd3,
    STA = 4'd4,
    LDI = 4'd5,
    JMP = 4'd6,
    OUT = 4'd14,
    HLT = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_IR,
    SRC_A,
    SRC_ALU,
    SRC_PC
  } src_e;

  function automatic src_e bus_src(
    input logic ro,
    input logic io,
    input logic ao,
    input logic sumo,
    input logic co
  );
    if (ro) return SRC_RAM;
    else if (io) return SRC_IR;
    else if (ao) return SRC_A;
    else if (sumo) return SRC_ALU;
    else if (co) return SRC_PC;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/datapath_core_if.sv
// Decoder-to-datapath bundle: control strobes, RAM programming port, status.
interface datapath_core_if
  import beneater_pkg::*;
  ;

  logic hlt, mi, ri, ro, io, ii, ai, ao;
  logic sumo, sub, bi, oi, ce, co, j;

  logic              prog_mode;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;

  logic [DATA_W-1:0] insn;
  logic [DATA_W-1:0] bus;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] out_val;
  logic              out_valid;
  logic              carry;
  logic              zero;
  logic              bus_conflict;

  modport master (
    output hlt, mi, ri, ro, io, ii, ai, ao,
    output sumo, sub, bi, oi, ce, co, j,
    output prog_mode, prog_we, prog_addr, prog_data,
    input  insn, bus, pc, out_val, out_valid,
    input  carry, zero, bus_conflict
  );

  modport slave (
    input  hlt, mi, ri, ro, io, ii, ai, ao,
    input  sumo, sub, bi, oi, ce, co, j,
    input  prog_mode, prog_we, prog_addr, prog_data,
    output insn, bus, pc, out_val, out_valid,
    output carry, zero, bus_conflict
  );

endinterface

// File: rtl/ram16x8.sv
// Program/data RAM: asynchronous read, synchronous write, storage not reset.
module ram16x8
  import beneater_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/datapath_core.sv
// SAP-style 8-bit datapath: bus mux, A/B, ALU, IR, PC, MAR, RAM, output reg.
module datapath_core
  import beneater_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  datapath_core_if.slave dp
);

  logic [DATA_W-1:0] a, b, ir, out_q;
  logic [ADDR_W-1:0] pc_q, mar;
  logic              cy, zf, ov;

  logic [DATA_W-1:0] ram_q, bus_v, alu;
  logic [DATA_W:0]   sum;
  logic              run;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;
  src_e              src;

  assign run = !dp.hlt && !dp.prog_mode;

  assign sum = {1'b0, a}
             + {1'b0, (dp.sub ? ~b : b)}
             + {{DATA_W{1'b0}}, dp.sub};
  assign alu = sum[DATA_W-1:0];

  assign src = bus_src(dp.ro, dp.io, dp.ao, dp.sumo, dp.co);

  always_comb begin
    bus_v = '0;
    case (src)
      SRC_RAM: bus_v = ram_q;
      SRC_IR:  bus_v = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
      SRC_A:   bus_v = a;
      SRC_ALU: bus_v = alu;
      SRC_PC:  bus_v = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      default: bus_v = '0;
    endcase
  end

  // Writes are gated by rst so an asserted reset can never land a store.
  assign ram_we = rst && (dp.prog_mode ? dp.prog_we : (!dp.hlt && dp.ri));
  assign ram_wa = dp.prog_mode ? dp.prog_addr : mar;
  assign ram_wd = dp.prog_mode ? dp.prog_data : bus_v;

  ram16x8 u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_wa),
    .wdata (ram_wd),
    .raddr (mar),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a     <= '0;
      b     <= '0;
      ir    <= '0;
      pc_q  <= '0;
      mar   <= '0;
      out_q <= '0;
      cy    <= 1'b0;
      zf    <= 1'b0;
      ov    <= 1'b0;
    end else begin
      ov <= run && dp.oi;
      if (run) begin
        if (dp.mi) mar <= bus_v[ADDR_W-1:0];
        if (dp.ii) ir <= bus_v;
        if (dp.ai) a <= bus_v;
        if (dp.bi) b <= bus_v;
        if (dp.oi) out_q <= bus_v;
        if (dp.j) pc_q <= bus_v[ADDR_W-1:0];
        else if (dp.ce) pc_q <= pc_q + 1'b1;
        if (dp.ai && dp.sumo) begin
          cy <= sum[DATA_W];
          zf <= (alu == '0);
        end
      end
    end

  assign dp.insn         = ir;
  assign dp.bus          = bus_v;
  assign dp.pc           = pc_q;
  assign dp.out_val      = out_q;
  assign dp.out_valid    = ov;
  assign dp.carry        = cy;
  assign dp.zero         = zf;
  assign dp.bus_conflict = (32'($countones({dp.ro, dp.io, dp.ao,
                                             dp.sumo, dp.co})) > 32'd1);

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core with a per-cycle behavioural model.
module tb_datapath_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  datapath_core_if dif();

  datapath_core dut (
    .clk (clk),
    .rst (rst),
    .dp  (dif)
  );

  int total = 0;
  int bad = 0;

  localparam logic [14:0] C_HLT  = 15'h4000;
  localparam logic [14:0] C_MI   = 15'h2000;
  localparam logic [14:0] C_RI   = 15'h1000;
  localparam logic [14:0] C_RO   = 15'h0800;
  localparam logic [14:0] C_IO   = 15'h0400;
  localparam logic [14:0] C_II   = 15'h0200;
  localparam logic [14:0] C_AI   = 15'h0100;
  localparam logic [14:0] C_AO   = 15'h0080;
  localparam logic [14:0] C_SUMO = 15'h0040;
  localparam logic [14:0] C_SUB  = 15'h0020;
  localparam logic [14:0] C_BI   = 15'h0010;
  localparam logic [14:0] C_OI   = 15'h0008;
  localparam logic [14:0] C_CE   = 15'h0004;
  localparam logic [14:0] C_CO   = 15'h0002;
  localparam logic [14:0] C_J    = 15'h0001;

  logic [7:0] ma, mb, mir, mout;
  logic [3:0] mpc, mmar;
  logic       mc, mz, mov;
  logic [7:0] mram [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    ma = 0; mb = 0; mir = 0; mout = 0;
    mpc = 0; mmar = 0; mc = 0; mz = 0; mov = 0;
  endtask

  function automatic logic [7:0] m_alu();
    int s;
    s = dif.sub ? int'(ma) - int'(mb) : int'(ma) + int'(mb);
    return s[7:0];
  endfunction

  function automatic logic m_carry();
    if (dif.sub) return ma >= mb;
    return (int'(ma) + int'(mb)) > 255;
  endfunction

  function automatic logic [7:0] m_bus();
    if (dif.ro) return mram[mmar];
    if (dif.io) return {4'h0, mir[3:0]};
    if (dif.ao) return ma;
    if (dif.sumo) return m_alu();
    if (dif.co) return {4'h0, mpc};
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    logic [7:0] bv, av;
    logic       run, cv;
    if (rst) begin
      bv = m_bus();
      av = m_alu();
      cv = m_carry();
      run = !dif.hlt && !dif.prog_mode;
      if (dif.prog_mode && dif.prog_we) mram[dif.prog_addr] = dif.prog_data;
      else if (run && dif.ri) mram[mmar] = bv;
      mov = run && dif.oi;
      if (run) begin
        if (dif.ai && dif.sumo) begin
          mc = cv;
          mz = (av == 8'h00);
        end
        if (dif.mi) mmar = bv[3:0];
        if (dif.ii) mir = bv;
        if (dif.ai) ma = bv;
        if (dif.bi) mb = bv;
        if (dif.oi) mout = bv;
        if (dif.j) mpc = bv[3:0];
        else if (dif.ce) mpc = mpc + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = int'(dif.ro) + int'(dif.io) + int'(dif.ao)
      + int'(dif.sumo) + int'(dif.co);
    chk("bus", dif.bus, m_bus());
    chk("conflict", dif.bus_conflict, n > 1);
    chk("insn", dif.insn, mir);
    chk("pc", dif.pc, mpc);
    chk("out_val", dif.out_val, mout);
    chk("out_valid", dif.out_valid, mov);
    chk("carry", dif.carry, mc);
    chk("zero", dif.zero, mz);
  end

  task automatic step(input logic [14:0] c, input logic pm = 1'b0,
                      input logic we = 1'b0, input logic [3:0] pa = 4'h0,
                      input logic [7:0] pd = 8'h00);
    @(negedge clk);
    #1;
    {dif.hlt, dif.mi, dif.ri, dif.ro, dif.io, dif.ii, dif.ai, dif.ao,
     dif.sumo, dif.sub, dif.bi, dif.oi, dif.ce, dif.co, dif.j} = c;
    dif.prog_mode = pm;
    dif.prog_we   = we;
    dif.prog_addr = pa;
    dif.prog_data = pd;
  endtask

  task automatic prog(input logic [3:0] addr, input logic [7:0] data);
    step(15'h0, 1'b1, 1'b1, addr, data);
  endtask

  initial begin
    {dif.hlt, dif.mi, dif.ri, dif.ro, dif.io, dif.ii, dif.ai, dif.ao,
     dif.sumo, dif.sub, dif.bi, dif.oi, dif.ce, dif.co, dif.j} = '0;
    dif.prog_mode = 1'b0;
    dif.prog_we   = 1'b0;
    dif.prog_addr = '0;
    dif.prog_data = '0;
    m_reset();

    step(15'h0);
    step(15'h0);
    chk("rst_pc", dif.pc, 4'h0);
    chk("rst_insn", dif.insn, 8'h00);
    chk("rst_outv", dif.out_valid, 1'b0);
    #2 rst = 1'b1;

    prog(4'd0, 8'h1E);  prog(4'd1, 8'hFC);  prog(4'd2, 8'h03);
    prog(4'd3, 8'h0F);  prog(4'd4, 8'h63);  prog(4'd7, 8'h2A);
    prog(4'd8, 8'h55);  prog(4'd11, 8'h10); prog(4'd14, 8'h07);
    prog(4'd15, 8'h05);

    step(C_MI | C_CO);
    step(C_RO | C_II | C_CE);
    step(15'h0);
    chk("fetch_ir", dif.insn, 8'h1E);
    chk("fetch_pc", dif.pc, 4'h1);

    step(C_IO | C_MI);
    step(C_RO | C_AI);
    step(C_MI | C_CO);
    step(C_RO | C_BI);
    step(C_AI | C_SUMO);
    step(C_AO);
    #1 chk("add_a", dif.bus, 8'h03);
    chk("add_c", dif.carry, 1'b1);
    chk("add_z", dif.zero, 1'b0);

    step(C_CE);
    step(C_MI | C_CO);
    step(C_RO | C_BI);
    step(C_SUB | C_AI | C_SUMO);
    step(C_AO);
    #1 chk("sub_a", dif.bus, 8'h00);
    chk("sub_c", dif.carry, 1'b1);
    chk("sub_z", dif.zero, 1'b1);

    step(C_CE);
    step(C_CE);
    step(C_MI | C_CO);
    step(C_RO | C_II);
    step(C_IO | C_J);
    step(C_MI | C_CO);
    chk("jmp_pc", dif.pc, 4'h3);
    step(C_RO | C_J);
    step(C_MI | C_CO);
    chk("pc_f", dif.pc, 4'hF);
    step(C_CE);
    step(C_RO | C_CE | C_J);
    chk("pc_wrap", dif.pc, 4'h0);
    step(15'h0);
    chk("pc_jwin", dif.pc, 4'h5);

    step(C_CE);
    step(C_CE);
    step(C_MI | C_CO);
    step(C_RO | C_AI);
    step(C_AO | C_OI);
    step(15'h0);
    chk("out_val", dif.out_val, 8'h2A);
    chk("out_v1", dif.out_valid, 1'b1);
    step(15'h0);
    chk("out_v0", dif.out_valid, 1'b0);

    step(C_CE);
    step(C_MI | C_CO);
    step(C_RO | C_AO);
    #1 chk("cfl_bus", dif.bus, 8'h55);
    chk("cfl_flag", dif.bus_conflict, 1'b1);

    step(C_HLT | C_RO | C_AI | C_CE);
    step(C_AO);
    #1 chk("hlt_a", dif.bus, 8'h2A);
    chk("hlt_pc", dif.pc, 4'h8);

    step(C_RO | C_AI | C_CE, 1'b1, 1'b1, 4'd10, 8'h5A);
    step(C_AO);
    #1 chk("pm_a", dif.bus, 8'h2A);
    chk("pm_pc", dif.pc, 4'h8);
    step(C_CE);
    step(C_CE);
    step(C_MI | C_CO);
    step(C_RO);
    #1 chk("pm_ram", dif.bus, 8'h5A);
    step(C_RO, 1'b0, 1'b1, 4'd10, 8'h11);
    step(C_RO);
    #1 chk("we_ign", dif.bus, 8'h5A);

    step(C_CE);
    step(C_MI | C_CO);
    step(C_RO | C_AI);
    prog(4'd3, 8'h99);
    step(C_IO | C_MI);
    step(C_AO);
    #1 chk("pre_rst_a", dif.bus, 8'h10);
    step(C_AO | C_RI);
    #2 rst = 1'b0;
    m_reset();
    step(15'h0);
    step(C_AO);
    #1 chk("rst_a", dif.bus, 8'h00);
    chk("rst_pc2", dif.pc, 4'h0);
    chk("rst_c", dif.carry, 1'b0);
    chk("rst_z", dif.zero, 1'b0);
    chk("rst_out", dif.out_val, 8'h00);
    #2 rst = 1'b1;

    step(C_CE);
    step(C_CE);
    step(C_CE);
    step(C_MI | C_CO);
    step(C_RO);
    #1 chk("ram_keep", dif.bus, 8'h99);
    step(15'h0);
    step(15'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_core.md
# datapath_core

8-bit datapath of the SAP-style CPU: bus, A/B registers, ALU, instruction register, 4-bit program counter, memory address register, 16×8 RAM and output register. It sits directly downstream of the microcode decoder and consumes its one-hot control strobes. It returns the current instruction byte to the decoder and exposes the RAM programming port used while `prog_mode` is high.

## Interface
- `DATA_W`, 8: bus/register width.
- `ADDR_W`, 4: RAM address, PC and MAR width; RAM depth is 2^ADDR_W.
- `clk`  in  1: system clock. Datapath state updates on the rising edge; the decoder updates controls on the falling edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j`  in  1 each: decoder control strobes.
- `prog_mode`  in  1: programming mode.
- `prog_we`  in  1: programming write strobe.
- `prog_addr`  in  ADDR_W: programming write address.
- `prog_data`  in  DATA_W: programming write data.
- `insn`  out  DATA_W: IR contents, fed to the decoder.
- `bus`  out  DATA_W: current bus value, for debug.
- `pc`  out  ADDR_W: program counter.
- `out_val`  out  DATA_W: output register.
- `out_valid`  out  1: one-cycle pulse when `out_val` is updated.
- `carry, zero`  out  1 each: ALU flags.
- `bus_conflict`  out  1: combinational; high when two or more bus drivers are enabled.

## Operation
**Bus drivers (combinational, fixed priority):** `ro` > `io` > `ao` > `sumo` > `co`.
- `ro`: RAM[MAR].
- `io`: {4'h0, IR[3:0]}.
- `ao`: A.
- `sumo`: ALU result.
- `co`: {4'h0, PC}.
- No driver enabled: bus = 8'h00.
- `bus_conflict` = more than one of `ro/io/ao/sumo/co` high. The priority winner still drives the bus.

**ALU:** 9-bit sum of A + (sub ? ~B : B) + sub. Result = low 8 bits; carry_next = bit 8. In subtract mode a carry of 1 means no borrow.

**Loads on the rising edge:** each applies only when not halted and not in `prog_mode`.
- `mi`: MAR ← bus[3:0].
- `ri`: RAM[MAR] ← bus.
- `ii`: IR ← bus.
- `ai`: A ← bus.
- `bi`: B ← bus.
- `oi`: out_val ← bus; `out_valid` = 1 for the next cycle only.
- `j`: PC ← bus[3:0].
- `ce`: PC ← PC+1, wrapping 4'hF → 4'h0.
- `j` and `ce` both high: `j` wins.
- `ai` and `sumo` both high: carry ← carry_next and zero ← (result == 0), latched in the same edge as A. Flags hold otherwise.
- Several load strobes high in the same cycle: all of them load the same bus value.

**Halt:** `hlt` high freezes every register and RAM write. Combinational outputs stay live. Operation resumes on the first edge after `hlt` falls.

**Programming:**
- `prog_mode` high: all control strobes are ignored.
- `prog_mode` and `prog_we` high: RAM[prog_addr] ← prog_data.
- PC, MAR and IR hold.
- `prog_we` with `prog_mode` low is ignored.

**Reset (`rst` low):**
- A, B, IR, PC, MAR, out_val = 0.
- carry, zero, out_valid = 0.
- RAM contents are not reset and are preserved across reset. This lets a program be loaded and then the CPU reset.
- Reset asserted mid-instruction aborts it immediately. No partial write completes after the asynchronous edge.

## Timing
- The decoder drives strobes on the falling edge; the datapath samples them on the next rising edge, half a cycle later.
- Each strobe is a level; it acts on every rising edge it is sampled high.
- RAM read is asynchronous: the bus reflects RAM[MAR] in the same cycle MAR is valid.
- Write-then-read of the same address returns the new data from the cycle after the write edge.
- `insn`, `pc` and `out_val` are register outputs with zero combinational delay.
- `bus` and `bus_conflict` are combinational.
- Loads take effect with one-edge latency. `out_valid` goes high on the edge that loads `out_val` and falls on the following edge unless `oi` is held.

## Structure
- Package `beneater_pkg`: `DATA_W`/`ADDR_W` constants, an opcode enum (LDA=1, ADD=2, SUB=3, STA=4, LDI=5, JMP=6, OUT=14, HLT=15) shared with the decoder, and a bus-source enum (NONE, RAM, IR, A, ALU, PC).
- One sub-module, `ram16x8`: asynchronous read, synchronous write, write-port mux (programming vs. `ri`) kept outside it, no reset on storage.
- ALU, bus mux and registers stay inline in `datapath_core`.

## Test plan
- **Program and fetch:** prog-write RAM[0]=8'h1E, RAM[14]=8'h07; run `mi,co` then `ro,ii,ce` → IR=8'h1E, pc=1.
- **Load and add:** A=8'h07, B=8'hFC; `ai,sumo` → A=8'h03, carry=1, zero=0. Then B=8'h03, `sub`+`ai,sumo` → A=8'h00, carry=1, zero=1.
- **Jump and PC priority:** IR=8'h63; `io,j` → pc=3. PC=4'hF with `ce` → pc=0. `ce` and `j` together with bus=8'h05 → pc=5.
- **Output and bus conflict:** A=8'h2A; `ao,oi` → out_val=8'h2A with `out_valid` high exactly one cycle. `ro` and `ao` together → bus=RAM[MAR], `bus_conflict`=1.
- **Halt and programming ignore controls:** `hlt` held while `ai` with bus=8'h55 → A unchanged. In `prog_mode`, `ai`/`ce` pulses → A and PC unchanged while RAM writes land.
- **Reset mid-instruction:** after loading A=8'h10 and writing RAM[3]=8'h99, assert `rst` low → all registers and flags 0; RAM[3] still reads 8'h99 after release.
